// File: rtl/stopwatch_pkg.sv
// Shared types and seven-segment tables for the BCD stopwatch.
//   bcd_t      : one BCD digit
//   hms_t      : six-digit {h1,h0,m1,m0,s1,s0} time payload
//   SEG_DIGIT  : active-high {g,f,e,d,c,b,a} patterns for 0..9
//   SEG_ALL_ON : lamp-test pattern ("8")
package stopwatch_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned SEG_W = 7;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef struct packed {
    bcd_t h1;
    bcd_t h0;
    bcd_t m1;
    bcd_t m0;
    bcd_t s1;
    bcd_t s0;
  } hms_t;

  localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  localparam logic [SEG_W-1:0] SEG_ALL_ON = 7'h7F;

  // Clamp a digit to an upper bound.
  function automatic bcd_t bcd_sat(bcd_t d, bcd_t max);
    return (d > max) ? max : d;
  endfunction

  // Active-high pattern for a digit; non-decimal codes blank the display.
  function automatic logic [SEG_W-1:0] seg_of(bcd_t d);
    return (d > 4'd9) ? '0 : SEG_DIGIT[d];
  endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// Single BCD digit up/down counter with synchronous preset.
//   clock, reset : rising-edge clock, async active-low reset
//   set, set_val : synchronous load (highest priority)
//   inc, dec     : step up / down, wrapping at MAX / 0
//   q            : registered digit
//   carry_c      : combinational, inc while q == MAX
//   borrow_c     : combinational, dec while q == 0
module bcd_digit_cnt
  import stopwatch_pkg::*;
#(
  parameter bcd_t MAX = 4'd9
) (
  input  logic clock,
  input  logic reset,
  input  logic set,
  input  bcd_t set_val,
  input  logic inc,
  input  logic dec,
  output bcd_t q,
  output logic carry_c,
  output logic borrow_c
);

  // Digit register: preset wins over stepping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (set) begin
      q <= set_val;
    end else if (inc) begin
      q <= (q == MAX) ? '0 : q + 4'd1;
    end else if (dec) begin
      q <= (q == '0) ? MAX : q - 4'd1;
    end
  end

  assign carry_c  = inc && (q == MAX);
  assign borrow_c = dec && (q == '0);

endmodule

// File: rtl/bcd_stopwatch.sv
// HH:MM:SS stopwatch / countdown timer driving six seven-segment displays.
//   clock, reset       : rising-edge clock, async active-low reset
//   run                : enable prescaler and counting
//   clear / load       : sync preset to 00:00:00 / saturated load_bcd (clear wins)
//   load_bcd[23:0]     : {h1,h0,m1,m0,s1,s0}
//   mode_down          : 0 count up, 1 count down
//   finish             : lamp test, all displays show "8"
//   lap                : display freeze toggle (used only with LAP_EN)
//   hr1..sec0[6:0]     : {g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW
//   tick               : one-cycle pulse per counted second
//   expired            : sticky countdown-reached-zero flag
// Optional feature macro: LAP_EN (lap-freeze display).
module bcd_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV       = 50_000_000,
  parameter int unsigned HR_MAX         = 99,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             clear,
  input  logic             load,
  input  logic [23:0]      load_bcd,
  input  logic             mode_down,
  input  logic             finish,
  input  logic             lap,
  output logic [SEG_W-1:0] hr1,
  output logic [SEG_W-1:0] hr0,
  output logic [SEG_W-1:0] min1,
  output logic [SEG_W-1:0] min0,
  output logic [SEG_W-1:0] sec1,
  output logic [SEG_W-1:0] sec0,
  output logic             tick,
  output logic             expired
);

  localparam int unsigned      PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam bcd_t             HR_T     = bcd_t'(HR_MAX / 10);
  localparam bcd_t             HR_U     = bcd_t'(HR_MAX % 10);

  logic [PRE_W-1:0] pre;
  hms_t cur, ld_sat, set_val, shown;
  bcd_t q_h1, q_h0, q_m1, q_m0, q_s1, q_s0;
  logic wrap, zero, is_one, step_up, step_dn, sync_set;
  logic hr_wrap_up, hr_wrap_dn, hr_set;
  bcd_t hr1_val, hr0_val;
  logic c_s0, c_s1, c_m0, c_m1, c_h0, unused_c_h1;
  logic b_s0, b_s1, b_m0, b_m1, b_h0, unused_b_h1;

  assign cur      = {q_h1, q_h0, q_m1, q_m0, q_s1, q_s0};
  assign zero     = (cur == '0);
  assign is_one   = (cur == hms_t'(24'h000001));
  assign wrap     = run && (pre == PRE_LAST);
  assign sync_set = clear || load;
  // Expired countdowns hold; counting up always proceeds.
  assign step_up  = wrap && !mode_down;
  assign step_dn  = wrap && mode_down && !expired && !zero;

  // Saturate load digits, then clamp the hour pair (BCD compares like binary).
  always_comb begin
    ld_sat.h1 = bcd_sat(load_bcd[23:20], 4'd9);
    ld_sat.h0 = bcd_sat(load_bcd[19:16], 4'd9);
    ld_sat.m1 = bcd_sat(load_bcd[15:12], 4'd5);
    ld_sat.m0 = bcd_sat(load_bcd[11:8],  4'd9);
    ld_sat.s1 = bcd_sat(load_bcd[7:4],   4'd5);
    ld_sat.s0 = bcd_sat(load_bcd[3:0],   4'd9);
    if ({ld_sat.h1, ld_sat.h0} > {HR_T, HR_U}) begin
      ld_sat.h1 = HR_T;
      ld_sat.h0 = HR_U;
    end
  end

  assign set_val = clear ? hms_t'('0) : ld_sat;

  // Hour pair wraps on a compare against HR_MAX rather than per-digit limits.
  assign hr_wrap_up = c_m1 && ({q_h1, q_h0} == {HR_T, HR_U});
  assign hr_wrap_dn = b_m1 && ({q_h1, q_h0} == 8'h00);
  assign hr_set     = sync_set || hr_wrap_up || hr_wrap_dn;
  assign hr1_val    = sync_set ? set_val.h1 : (hr_wrap_up ? '0 : HR_T);
  assign hr0_val    = sync_set ? set_val.h0 : (hr_wrap_up ? '0 : HR_U);

  bcd_digit_cnt #(.MAX(4'd9)) u_s0 (
    .clock(clock), .reset(reset), .set(sync_set), .set_val(set_val.s0),
    .inc(step_up), .dec(step_dn), .q(q_s0), .carry_c(c_s0), .borrow_c(b_s0)
  );
  bcd_digit_cnt #(.MAX(4'd5)) u_s1 (
    .clock(clock), .reset(reset), .set(sync_set), .set_val(set_val.s1),
    .inc(c_s0), .dec(b_s0), .q(q_s1), .carry_c(c_s1), .borrow_c(b_s1)
  );
  bcd_digit_cnt #(.MAX(4'd9)) u_m0 (
    .clock(clock), .reset(reset), .set(sync_set), .set_val(set_val.m0),
    .inc(c_s1), .dec(b_s1), .q(q_m0), .carry_c(c_m0), .borrow_c(b_m0)
  );
  bcd_digit_cnt #(.MAX(4'd5)) u_m1 (
    .clock(clock), .reset(reset), .set(sync_set), .set_val(set_val.m1),
    .inc(c_m0), .dec(b_m0), .q(q_m1), .carry_c(c_m1), .borrow_c(b_m1)
  );
  bcd_digit_cnt #(.MAX(4'd9)) u_h0 (
    .clock(clock), .reset(reset), .set(hr_set), .set_val(hr0_val),
    .inc(c_m1), .dec(b_m1), .q(q_h0), .carry_c(c_h0), .borrow_c(b_h0)
  );
  bcd_digit_cnt #(.MAX(4'd9)) u_h1 (
    .clock(clock), .reset(reset), .set(hr_set), .set_val(hr1_val),
    .inc(c_h0), .dec(b_h0), .q(q_h1), .carry_c(unused_c_h1), .borrow_c(unused_b_h1)
  );

  // Prescaler, tick pulse and sticky expiry; tick survives a same-edge clear/load.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pre     <= '0;
      tick    <= 1'b0;
      expired <= 1'b0;
    end else begin
      tick <= wrap && !(mode_down && expired);
      if (sync_set) begin
        pre     <= '0;
        expired <= 1'b0;
      end else begin
        if (run) pre <= wrap ? '0 : pre + PRE_W'(1);
        // Only 00:00:01 steps down onto zero; at zero the flag sets without a step.
        if (wrap && mode_down && (zero || is_one)) expired <= 1'b1;
      end
    end
  end

`ifdef LAP_EN
  logic lap_q, frozen;
  hms_t lap_reg;

  // Lap edge toggles freeze; entering freeze captures the live digits.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lap_q   <= 1'b0;
      frozen  <= 1'b0;
      lap_reg <= '0;
    end else begin
      lap_q <= lap;
      if (sync_set) begin
        frozen <= 1'b0;
      end else if (lap && !lap_q) begin
        frozen <= !frozen;
        if (!frozen) lap_reg <= cur;
      end
    end
  end

  assign shown = frozen ? lap_reg : cur;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign shown      = cur;
`endif

  function automatic logic [SEG_W-1:0] seg_drive(bcd_t d, logic all_on);
    logic [SEG_W-1:0] p;
    p = all_on ? SEG_ALL_ON : seg_of(d);
    return SEG_ACTIVE_LOW ? ~p : p;
  endfunction

  assign hr1  = seg_drive(shown.h1, finish);
  assign hr0  = seg_drive(shown.h0, finish);
  assign min1 = seg_drive(shown.m1, finish);
  assign min0 = seg_drive(shown.m0, finish);
  assign sec1 = seg_drive(shown.s1, finish);
  assign sec0 = seg_drive(shown.s0, finish);

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Self-checking bench for bcd_stopwatch (TICK_DIV=4, HR_MAX=23, active-low segments).
// Reference model keeps time as a plain seconds count; lap checks enabled with LAP_EN.
module tb_bcd_stopwatch;

  localparam int TD     = 4;
  localparam int HRM    = 23;
  localparam int PERIOD = (HRM + 1) * 3600;

  logic        clock, reset, run, clear, load, mode_down, finish, lap;
  logic [23:0] load_bcd;
  logic [6:0]  hr1, hr0, min1, min0, sec1, sec0;
  logic        tick, expired;

  int n_cmp = 0;
  int n_bad = 0;
  int tick_cnt = 0;

  // Reference model state
  int m_secs, m_pre, m_lap;
  bit m_exp, m_tick, m_frozen, m_lapq;

  bcd_stopwatch #(.TICK_DIV(TD), .HR_MAX(HRM), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clock(clock), .reset(reset), .run(run), .clear(clear), .load(load),
    .load_bcd(load_bcd), .mode_down(mode_down), .finish(finish), .lap(lap),
    .hr1(hr1), .hr0(hr0), .min1(min1), .min0(min0), .sec1(sec1), .sec0(sec0),
    .tick(tick), .expired(expired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [6:0] seg_hi(int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  // Expected active-low display bus for a seconds value.
  function automatic logic [41:0] disp_of(int secs, bit fin);
    int hh, mm, ss;
    logic [41:0] r;
    hh = secs / 3600;
    mm = (secs / 60) % 60;
    ss = secs % 60;
    if (fin) r = {6{7'b1111111}};
    else r = {seg_hi(hh / 10), seg_hi(hh % 10), seg_hi(mm / 10), seg_hi(mm % 10),
              seg_hi(ss / 10), seg_hi(ss % 10)};
    return ~r;
  endfunction

  // Saturating conversion of a {h1,h0,m1,m0,s1,s0} word into seconds.
  function automatic int sat_load(logic [23:0] b);
    int d[6];
    int hh, mm, ss;
    for (int i = 0; i < 6; i++) d[i] = int'(b[23 - 4 * i -: 4]);
    hh = ((d[0] > 9) ? 9 : d[0]) * 10 + ((d[1] > 9) ? 9 : d[1]);
    if (hh > HRM) hh = HRM;
    mm = ((d[2] > 5) ? 5 : d[2]) * 10 + ((d[3] > 9) ? 9 : d[3]);
    ss = ((d[4] > 5) ? 5 : d[4]) * 10 + ((d[5] > 9) ? 9 : d[5]);
    return hh * 3600 + mm * 60 + ss;
  endfunction

  function automatic void model_reset();
    m_secs = 0; m_pre = 0; m_exp = 0; m_tick = 0;
    m_frozen = 0; m_lapq = 0; m_lap = 0;
  endfunction

  // One clock edge of the reference model, from the specification's rules.
  function automatic void model_clock();
    bit wrap, exp_n;
    int secs_n;
    wrap   = run && (m_pre == TD - 1);
    secs_n = m_secs;
    exp_n  = m_exp;
    if (wrap) begin
      if (!mode_down) secs_n = (m_secs + 1) % PERIOD;
      else if (!m_exp) begin
        if (m_secs == 0) exp_n = 1;
        else begin
          secs_n = m_secs - 1;
          if (secs_n == 0) exp_n = 1;
        end
      end
    end
    m_tick = wrap && !(mode_down && m_exp);
`ifdef LAP_EN
    begin
      bit edge_det;
      edge_det = lap && !m_lapq;
      m_lapq = lap;
      if (clear || load) m_frozen = 0;
      else if (edge_det) begin
        if (!m_frozen) m_lap = m_secs;
        m_frozen = !m_frozen;
      end
    end
`endif
    if (clear) begin
      secs_n = 0; exp_n = 0;
    end else if (load) begin
      secs_n = sat_load(load_bcd); exp_n = 0;
    end
    if (clear || load) m_pre = 0;
    else if (run) m_pre = wrap ? 0 : m_pre + 1;
    m_secs = secs_n;
    m_exp  = exp_n;
  endfunction

  function automatic logic [41:0] disp_act();
    return {hr1, hr0, min1, min0, sec1, sec0};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge, update the model, compare all outputs.
  task automatic cycle();
    @(posedge clock);
    model_clock();
    #1;
    if (tick === 1'b1) tick_cnt++;
    check("disp", 64'(disp_act()), 64'(disp_of(m_frozen ? m_lap : m_secs, finish)));
    check("tick", 64'(tick), 64'(m_tick));
    check("expired", 64'(expired), 64'(m_exp));
  endtask

  typedef struct {
    bit          run, clr, ld, down, fin;
    logic [23:0] bcd;
    int          cycles;
    logic [23:0] exp_bcd;
    bit          exp_exp;
    int          exp_ticks;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit c, bit l, bit d, bit f, logic [23:0] b, int n,
                              logic [23:0] eb, bit ee, int et);
    vec_t v;
    v.run = r; v.clr = c; v.ld = l; v.down = d; v.fin = f; v.bcd = b; v.cycles = n;
    v.exp_bcd = eb; v.exp_exp = ee; v.exp_ticks = et;
    return v;
  endfunction

  initial begin
    reset = 1'b0; run = 0; clear = 0; load = 0; mode_down = 0; finish = 0; lap = 0;
    load_bcd = '0;
    model_reset();

    //          run clr ld dn fin  load_bcd  n    expect     exp ticks
    vecs.push_back(mk(0, 1, 0, 0, 0, 24'h0,      1, 24'h000000, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 24'h0,    240, 24'h000100, 0, 60));
    vecs.push_back(mk(0, 0, 1, 0, 0, 24'h235959, 1, 24'h235959, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 24'h0,      4, 24'h000000, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 24'h000002, 1, 24'h000002, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 24'h0,     12, 24'h000000, 1, 2));
    vecs.push_back(mk(1, 0, 0, 0, 0, 24'h0,      4, 24'h000001, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 24'h9F7A6B, 1, 24'h235959, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 24'h1A5C3D, 1, 24'h195939, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 24'h0,      4, 24'h195938, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 24'h000000, 1, 24'h000000, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 24'h0,      4, 24'h000000, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 24'h000010, 1, 24'h000010, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 24'h0,      4, 24'h000009, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 24'h100000, 1, 24'h100000, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 24'h0,      4, 24'h095959, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 24'h000005, 1, 24'h000005, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 24'h0,      8, 24'h000007, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 24'h0,      1, 24'h000007, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 24'h000003, 1, 24'h000003, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 24'h0,      3, 24'h000003, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 24'h0,      1, 24'h000000, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 24'h0,      2, 24'h000000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 24'h0,      5, 24'h000000, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 24'h0,      2, 24'h000001, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 24'h235959, 1, 24'h235959, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 24'h0,      4, 24'h235958, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 24'h0,      3, 24'h235958, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 24'h120000, 1, 24'h120000, 0, 1));

    // Reset state
    @(posedge clock);
    #1;
    check("reset_disp", 64'(disp_act()), 64'(disp_of(0, 0)));
    check("reset_tick", 64'(tick), 64'(0));
    check("reset_expired", 64'(expired), 64'(0));
    @(negedge clock);
    reset = 1'b1;

    foreach (vecs[i]) begin
      run = vecs[i].run; clear = vecs[i].clr; load = vecs[i].ld;
      mode_down = vecs[i].down; finish = vecs[i].fin; load_bcd = vecs[i].bcd;
      tick_cnt = 0;
      repeat (vecs[i].cycles) cycle();
      check($sformatf("vec%0d_disp", i), 64'(disp_act()),
            64'(disp_of(sat_load(vecs[i].exp_bcd), vecs[i].fin)));
      check($sformatf("vec%0d_expired", i), 64'(expired), 64'(vecs[i].exp_exp));
      check($sformatf("vec%0d_ticks", i), 64'(tick_cnt), 64'(vecs[i].exp_ticks));
    end

    // Asynchronous reset in mid-cycle with expired set and digits non-zero
    run = 0; clear = 0; finish = 0; mode_down = 0; load = 1; load_bcd = 24'h000001;
    cycle();
    load = 0; run = 1; mode_down = 1;
    repeat (4) cycle();
    mode_down = 0;
    repeat (8) cycle();
    check("pre_rst_disp", 64'(disp_act()), 64'(disp_of(2, 0)));
    check("pre_rst_expired", 64'(expired), 64'(1));
    check("pre_rst_tick", 64'(tick), 64'(1));
    #3;
    reset = 1'b0;
    #1;
    check("async_rst_disp", 64'(disp_act()), 64'(disp_of(0, 0)));
    check("async_rst_expired", 64'(expired), 64'(0));
    check("async_rst_tick", 64'(tick), 64'(0));
    model_reset();
    @(negedge clock);
    reset = 1'b1;

`ifdef LAP_EN
    // Lap freeze at 00:00:05, eight more seconds, release shows 00:00:13
    run = 0; clear = 1;
    cycle();
    clear = 0; run = 1;
    repeat (20) cycle();
    check("lap_pre", 64'(disp_act()), 64'(disp_of(5, 0)));
    lap = 1;
    cycle();
    lap = 0;
    repeat (31) cycle();
    check("lap_frozen", 64'(disp_act()), 64'(disp_of(5, 0)));
    lap = 1;
    cycle();
    lap = 0;
    check("lap_release", 64'(disp_act()), 64'(disp_of(13, 0)));
`endif

    // Randomized phase against the model
    mode_down = 0; lap = 0;
    for (int i = 0; i < 3000; i++) begin
      run    = ($urandom_range(0, 7) != 0);
      clear  = ($urandom_range(0, 99) == 0);
      load   = ($urandom_range(0, 49) == 0);
      load_bcd = ($urandom_range(0, 1) == 1) ? 24'($urandom) : 24'($urandom_range(0, 9));
      if ($urandom_range(0, 63) == 0) mode_down = ~mode_down;
      finish = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) == 0) lap = ~lap;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
